jpeg_rle_symbolizer: RTL and testbench

Run-length symbolizer for the JPEG encode path. It accepts one quantized coefficient per 8x8 block position, in zig-zag order. Position 0 is the DC difference; positions 1..63 are AC. It emits JPEG (run, size, amplitude) symbols, including ZRL and EOB, to the Huffman coding stage, which consumes them under ready/valid handshake. The block sits between the quantizer/zig-zag stage and the Huffman encoder cone.

---
 rtl/jpeg_rle_symbolizer.sv | 192 +++++++++++++++++++
 tb/tb_jpeg_rle_symbolizer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_rle_symbolizer.sv
// JPEG run-length symbolizer: turns zig-zag ordered quantized coefficients into
// (run, size, amplitude) symbols including ZRL and EOB, with registered output.
module jpeg_rle_symbolizer #(
  parameter int unsigned COEF_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_dc,
  output logic [3:0]        out_run,
  output logic [3:0]        out_size,
  output logic [COEF_W-1:0] out_amp,
  output logic              out_last
);

  typedef enum logic {ACCEPT, ZRL} state_t;

  localparam logic [COEF_W-1:0] ONE = COEF_W'(1);

  function automatic logic [3:0] coef_size(input logic [COEF_W-1:0] v);
    logic [COEF_W-1:0] mag;
    logic [3:0]        s;
    mag = v[COEF_W-1] ? (~v + ONE) : v;
    s   = '0;
    for (int unsigned i = 0; i < COEF_W; i++) begin
      if (mag[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

  // Negative values use JPEG one's complement form: (v-1) truncated to size bits.
  function automatic logic [COEF_W-1:0] coef_amp(input logic [COEF_W-1:0] v,
                                                 input logic [3:0]        size);
    logic [COEF_W-1:0] raw;
    logic [COEF_W-1:0] mask;
    raw  = v[COEF_W-1] ? (v - ONE) : v;
    mask = '0;
    for (int unsigned i = 0; i < COEF_W; i++) begin
      if (i < 32'(size)) mask[i] = 1'b1;
    end
    return raw & mask;
  endfunction

  state_t            state, state_n;
  logic [5:0]        idx, idx_n;
  logic [5:0]        zrun, zrun_n;
  logic [COEF_W-1:0] hold_coef, hold_coef_n;
  logic [5:0]        hold_idx, hold_idx_n;

  logic              ov_n, dc_n, last_n;
  logic [3:0]        run_n, size_n;
  logic [COEF_W-1:0] amp_n;

  logic              slot_free;
  logic              accept;
  logic [3:0]        in_size, hold_size;
  logic [COEF_W-1:0] in_amp, hold_amp;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && (state == ACCEPT) && slot_free;
  assign accept    = in_valid && in_ready;

  assign in_size   = coef_size(in_coef);
  assign in_amp    = coef_amp(in_coef, in_size);
  assign hold_size = coef_size(hold_coef);
  assign hold_amp  = coef_amp(hold_coef, hold_size);

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    zrun_n      = zrun;
    hold_coef_n = hold_coef;
    hold_idx_n  = hold_idx;
    ov_n        = out_valid;
    dc_n        = out_dc;
    run_n       = out_run;
    size_n      = out_size;
    amp_n       = out_amp;
    last_n      = out_last;

    if (out_valid && out_ready) begin
      ov_n   = 1'b0;
      last_n = 1'b0;
    end

    unique case (state)
      ACCEPT: begin
        if (accept) begin
          idx_n = idx + 6'd1;
          if (idx == 6'd0) begin
            ov_n   = 1'b1;
            dc_n   = 1'b1;
            run_n  = '0;
            size_n = in_size;
            amp_n  = in_amp;
            last_n = 1'b0;
            zrun_n = '0;
          end else if (in_coef == '0) begin
            if (idx == 6'd63) begin
              ov_n   = 1'b1;
              dc_n   = 1'b0;
              run_n  = '0;
              size_n = '0;
              amp_n  = '0;
              last_n = 1'b1;
              zrun_n = '0;
            end else begin
              zrun_n = zrun + 6'd1;
            end
          end else if (zrun[5:4] == 2'b00) begin
            ov_n   = 1'b1;
            dc_n   = 1'b0;
            run_n  = zrun[3:0];
            size_n = in_size;
            amp_n  = in_amp;
            last_n = (idx == 6'd63);
            zrun_n = '0;
          end else begin
            // The first ZRL goes out in the accepting slot so each ZRL costs
            // exactly one stalled input cycle.
            ov_n        = 1'b1;
            dc_n        = 1'b0;
            run_n       = 4'd15;
            size_n      = '0;
            amp_n       = '0;
            last_n      = 1'b0;
            zrun_n      = zrun - 6'd16;
            hold_coef_n = in_coef;
            hold_idx_n  = idx;
            state_n     = ZRL;
          end
        end
      end

      ZRL: begin
        if (slot_free) begin
          ov_n = 1'b1;
          dc_n = 1'b0;
          if (zrun[5:4] != 2'b00) begin
            run_n  = 4'd15;
            size_n = '0;
            amp_n  = '0;
            last_n = 1'b0;
            zrun_n = zrun - 6'd16;
          end else begin
            run_n   = zrun[3:0];
            size_n  = hold_size;
            amp_n   = hold_amp;
            last_n  = (hold_idx == 6'd63);
            zrun_n  = '0;
            state_n = ACCEPT;
          end
        end
      end

      default: state_n = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCEPT;
      idx       <= '0;
      zrun      <= '0;
      hold_coef <= '0;
      hold_idx  <= '0;
      out_valid <= 1'b0;
      out_dc    <= 1'b0;
      out_run   <= '0;
      out_size  <= '0;
      out_amp   <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      zrun      <= zrun_n;
      hold_coef <= hold_coef_n;
      hold_idx  <= hold_idx_n;
      out_valid <= ov_n;
      out_dc    <= dc_n;
      out_run   <= run_n;
      out_size  <= size_n;
      out_amp   <= amp_n;
      out_last  <= last_n;
    end
  end

endmodule

// File: tb/tb_jpeg_rle_symbolizer.sv
// Self-checking bench for jpeg_rle_symbolizer: block-level symbol model feeding
// an expected-symbol queue, one compare process, directed and random blocks.
module tb_jpeg_rle_symbolizer;

  localparam int unsigned COEF_W = 12;

  typedef struct packed {
    logic              dc;
    logic [3:0]        run;
    logic [3:0]        size;
    logic [COEF_W-1:0] amp;
    logic              last;
  } sym_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [COEF_W-1:0] in_coef = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_dc;
  logic [3:0]        out_run;
  logic [3:0]        out_size;
  logic [COEF_W-1:0] out_amp;
  logic              out_last;

  int   checks   = 0;
  int   failures = 0;
  int   rdy_mode = 0;   // 0: ready high, 1: random, 2: driven by main process
  sym_t exp_q[$];
  sym_t mq[$];

  jpeg_rle_symbolizer #(.COEF_W(COEF_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dc(out_dc), .out_run(out_run), .out_size(out_size),
    .out_amp(out_amp), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int csize(input int v);
    int m;
    int s;
    m = (v < 0) ? -v : v;
    s = 0;
    while (m > 0) begin
      s++;
      m = m >> 1;
    end
    return s;
  endfunction

  function automatic sym_t mk(input bit dc, input int run, input int v, input bit last);
    sym_t r;
    int   s;
    int   a;
    s = csize(v);
    if (v > 0)      a = v;
    else if (v < 0) a = v + (1 << s) - 1;
    else            a = 0;
    r.dc   = dc;
    r.run  = 4'(run);
    r.size = 4'(s);
    r.amp  = COEF_W'(a);
    r.last = last;
    return r;
  endfunction

  task automatic model_block(input int b[64]);
    int z;
    mq.delete();
    mq.push_back(mk(1'b1, 0, b[0], 1'b0));
    z = 0;
    for (int i = 1; i < 64; i++) begin
      if (b[i] == 0) begin
        if (i == 63) mq.push_back(mk(1'b0, 0, 0, 1'b1));
        else         z++;
      end else begin
        while (z >= 16) begin
          mq.push_back(mk(1'b0, 15, 0, 1'b0));
          z -= 16;
        end
        mq.push_back(mk(1'b0, z, b[i], i == 63));
        z = 0;
      end
    end
  endtask

  task automatic push_model(input int b[64]);
    model_block(b);
    foreach (mq[k]) exp_q.push_back(mq[k]);
  endtask

  task automatic send_coef(input int v, output int stalls);
    bit done;
    in_valid = 1'b1;
    in_coef  = COEF_W'(v);
    stalls   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else          stalls++;
      @(posedge clk);
      #1;
      if (!done && stalls > 2000) begin
        $display("FAIL send_timeout got=stalled exp=accept");
        $fatal(1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int b[64], input bit gaps, output int cycles, output int stalls);
    int s;
    push_model(b);
    cycles = 0;
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_coef(b[i], s);
      stalls += s;
      cycles += s + 1;
    end
  endtask

  task automatic tail_stalls(output int n);
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else          n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    sym_t got;
    sym_t e;
    if (!rst) begin
      check("last_implies_valid", out_last & ~out_valid, 0);
      if (out_valid && out_ready) begin
        got = {out_dc, out_run, out_size, out_amp, out_last};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_symbol got=%0h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          check("symbol", got, e);
        end
      end
    end
  end

  initial begin
    int b[64];
    int cyc;
    int st;
    int n;
    sym_t snap;
    sym_t cur;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_fields", {out_dc, out_run, out_size, out_amp, out_last}, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // All-zero block
    foreach (b[i]) b[i] = 0;
    send_block(b, 1'b0, cyc, st);
    check("zero_blk_cycles", cyc, 64);
    check("zero_blk_nsym", mq.size(), 2);
    check("zero_blk_dc", mq[0], mk(1'b1, 0, 0, 1'b0));
    check("zero_blk_eob", mq[1], {1'b0, 4'd0, 4'd0, 12'd0, 1'b1});

    // DC=-3, AC1=+5
    foreach (b[i]) b[i] = 0;
    b[0] = -3;
    b[1] = 5;
    send_block(b, 1'b0, cyc, st);
    check("m3_dc", mq[0], {1'b1, 4'd0, 4'd2, 12'd0, 1'b0});
    check("m3_ac", mq[1], {1'b0, 4'd0, 4'd3, 12'd5, 1'b0});
    check("m3_eob", mq[2], {1'b0, 4'd0, 4'd0, 12'd0, 1'b1});

    // DC=1, 20 zeros, +5 at idx 21
    foreach (b[i]) b[i] = 0;
    b[0]  = 1;
    b[21] = 5;
    send_block(b, 1'b0, cyc, st);
    check("zrl_blk_stalls", st, 1);
    check("zrl_blk_zrl", mq[1], {1'b0, 4'd15, 4'd0, 12'd0, 1'b0});
    check("zrl_blk_sym", mq[2], {1'b0, 4'd4, 4'd3, 12'd5, 1'b0});

    // DC=0, 62 zeros, idx63=-1
    foreach (b[i]) b[i] = 0;
    b[63] = -1;
    send_block(b, 1'b0, cyc, st);
    tail_stalls(n);
    check("last_zrl_stalls", n, 3);
    check("last_blk_nsym", mq.size(), 5);
    check("last_blk_sym", mq[4], {1'b0, 4'd14, 4'd1, 12'd0, 1'b1});

    // Backpressure on a pending DC symbol
    foreach (b[i]) b[i] = 0;
    b[0] = 7;
    b[1] = 2;
    push_model(b);
    rdy_mode  = 2;
    out_ready = 1'b1;
    send_coef(b[0], st);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_coef   = COEF_W'(b[1]);
    snap      = {out_dc, out_run, out_size, out_amp, out_last};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cur = {out_dc, out_run, out_size, out_amp, out_last};
      check("bp_valid", out_valid, 1);
      check("bp_stable", cur, snap);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    check("bp_pending", exp_q.size(), mq.size());
    out_ready = 1'b1;
    rdy_mode  = 0;
    send_coef(b[1], st);
    check("bp_consumed_first_edge", st, 0);
    for (int i = 2; i < 64; i++) send_coef(b[i], st);

    // Random blocks with random backpressure and input gaps
    rdy_mode = 1;
    for (int k = 0; k < 25; k++) begin
      int zp;
      case ($urandom_range(0, 2))
        0:       zp = 50;
        1:       zp = 85;
        default: zp = 97;
      endcase
      for (int i = 0; i < 64; i++) begin
        if (i > 0 && $urandom_range(0, 99) < zp) b[i] = 0;
        else if ($urandom_range(0, 1) == 0)      b[i] = $urandom_range(0, 14) - 7;
        else                                      b[i] = $urandom_range(0, 4095) - 2048;
      end
      send_block(b, 1'b1, cyc, st);
    end

    // Reset at idx 30 with a symbol pending
    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    foreach (b[i]) b[i] = (i < 30) ? 1 : 0;
    b[0] = 9;
    push_model(b);
    for (int i = 0; i < 30; i++) send_coef(b[i], st);
    rdy_mode  = 2;
    out_ready = 1'b0;
    @(negedge clk);
    check("pending_before_reset", out_valid, 1);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("reset_drops_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    rdy_mode  = 0;
    foreach (b[i]) b[i] = 0;
    b[0] = -5;
    b[3] = 100;
    b[40] = -2048;
    send_block(b, 1'b0, cyc, st);
    check("post_reset_dc", mq[0], {1'b1, 4'd0, 4'd3, 12'd2, 1'b0});

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    check("idle_after_drain", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
